// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and instruction format for the MiniAlu program loader.
package program_loader_pkg;
  localparam int BYTES_PER_INSTR = 4;
  localparam int OPCODE_W = 4;
  localparam int INSTR_W = OPCODE_W + 24;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} loaderState;
endpackage

// File: rtl/instr_byte_packer.sv
// instr_byte_packer: shifts MSB-first bytes into one instruction word, flagging first and last byte.
module instr_byte_packer
  import program_loader_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iShift,
  input  logic [7:0]         iByte,
  output logic [INSTR_W-1:0] oWord,
  output logic               oFirst,
  output logic               oLast
);
  logic [$clog2(BYTES_PER_INSTR)-1:0] byteCount;
  // The register is only INSTR_W wide, so the unused top nibble of byte 0 falls off the end.
  always_ff @(posedge Clock)
    if (!Reset) begin
      byteCount <= '0;
      oWord <= '0;
    end else if (iShift) begin
      byteCount <= byteCount + 1'b1;
      oWord <= {oWord[INSTR_W-9:0], iByte};
    end
  assign oFirst = byteCount == '0;
  assign oLast = iShift && byteCount == 2'(BYTES_PER_INSTR - 1);
endmodule

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into program RAM words and holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [ADDR_W:0]    iWordCount,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [INSTR_W-1:0] oWriteData,
  output logic               oCpuReset,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);
  loaderState state, nextState;
  logic [ADDR_W:0] wordsLeft;
  logic startOk, shift, first, last;
`ifdef LOADER_CHECKSUM_EN
  localparam loaderState FINAL = CHECK;
  logic [7:0] checksum;
`else
  localparam loaderState FINAL = DONE;
`endif
  assign startOk = iStart && (state == IDLE || state == DONE);
  assign shift = oByteReady && iByteValid && state == COLLECT;
  instr_byte_packer packer (
    .Clock (Clock),
    .Reset (Reset),
    .iShift(shift),
    .iByte (iByte),
    .oWord (oWriteData),
    .oFirst(first),
    .oLast (last)
  );
  always_ff @(posedge Clock)
    if (!Reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
`ifdef LOADER_CHECKSUM_EN
    oByteReady = state == COLLECT || state == CHECK;
    if (state == CHECK && iByteValid) nextState = DONE;
`else
    oByteReady = state == COLLECT;
`endif
    if (startOk) nextState = iWordCount == '0 ? FINAL : COLLECT;
    else if (state == COLLECT && last) nextState = WRITE;
    else if (state == WRITE) nextState = wordsLeft == (ADDR_W + 1)'(1) ? FINAL : COLLECT;
  end
  assign oWriteEnable = state == WRITE;
  assign oCpuReset = state != DONE;
  assign oBusy = state == COLLECT || state == WRITE || state == CHECK;
  assign oDone = state == DONE;
  always_ff @(posedge Clock)
    if (!Reset) begin
      oWriteAddress <= '0;
      wordsLeft <= '0;
      oError <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      if (startOk) begin
        oWriteAddress <= '0;
        wordsLeft <= iWordCount;
        oError <= 1'b0;
      end
      if (state == WRITE) begin
        oWriteAddress <= oWriteAddress + ADDR_W'(1);
        wordsLeft <= wordsLeft - (ADDR_W + 1)'(1);
      end
      if (shift && first && iByte[7:OPCODE_W] != '0) oError <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if (startOk) checksum <= '0;
      else if (shift) checksum <= checksum ^ iByte;
      if (state == CHECK && iByteValid && iByte != checksum) oError <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed vector bench for program_loader (8-bit and 2-bit address instances).
module tb_program_loader;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic iStart = 1'b0;
  logic iByteValid = 1'b0;
  logic [8:0] iWordCount = '0;
  logic [7:0] iByte = '0;
  logic rdy, we, cpuRst, busy, done, err;
  logic [7:0] wa;
  logic [27:0] wd;
  logic rdyS, weS, cpuRstS, busyS, doneS, errS;
  logic [1:0] waS;
  logic [27:0] wdS;
  logic [35:0] log8[$];
  logic [29:0] logS[$];
  logic [7:0] img[0:31];
  logic [7:0] sumReg;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [8:0]  cnt;
    logic [63:0] bytes;
    logic        toggle;
    logic [27:0] w0;
    logic [27:0] w1;
    logic        err;
  } vec_t;
  vec_t vecs[4];

  program_loader #(.ADDR_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iWordCount(iWordCount),
    .iByte(iByte), .iByteValid(iByteValid), .oByteReady(rdy), .oWriteEnable(we),
    .oWriteAddress(wa), .oWriteData(wd), .oCpuReset(cpuRst), .oBusy(busy),
    .oDone(done), .oError(err)
  );
  program_loader #(.ADDR_W(2)) dutS (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iWordCount(iWordCount[2:0]),
    .iByte(iByte), .iByteValid(iByteValid), .oByteReady(rdyS), .oWriteEnable(weS),
    .oWriteAddress(waS), .oWriteData(wdS), .oCpuReset(cpuRstS), .oBusy(busyS),
    .oDone(doneS), .oError(errS)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (we) log8.push_back({wa, wd});
    if (weS) logS.push_back({waS, wdS});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic startLoad(input logic [8:0] cnt);
    @(negedge Clock);
    iStart = 1'b1;
    iWordCount = cnt;
    sumReg = '0;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit toggle);
    int t;
    t = 0;
    iByte = b;
    iByteValid = 1'b1;
    while (!rdy && t < 20) begin
      @(negedge Clock);
      t++;
    end
    if (!rdy) check("byteReadyTimeout", 64'(rdy), 64'(1));
    @(negedge Clock);
    iByteValid = 1'b0;
    if (toggle) @(negedge Clock);
  endtask

  task automatic sendBytes(input int from, input int n, input bit toggle);
    for (int i = from; i < from + n; i++) begin
      sendByte(img[i], toggle);
      sumReg = sumReg ^ img[i];
    end
  endtask

  task automatic sendSum(input bit bad);
`ifdef LOADER_CHECKSUM_EN
    sendByte(bad ? ~sumReg : sumReg, 1'b0);
`else
    if (bad) sumReg = ~sumReg;
`endif
  endtask

  task automatic waitDone;
    int t;
    t = 0;
    while (!done && t < 200) begin
      @(negedge Clock);
      t++;
    end
    check("done", 64'(done), 64'(1));
  endtask

  initial begin
    vecs[0] = '{cnt: 9'd2, bytes: 64'h01020304_0A0B0C0D, toggle: 1'b0, w0: 28'h1020304, w1: 28'hA0B0C0D, err: 1'b0};
    vecs[1] = '{cnt: 9'd2, bytes: 64'hF1020304_0A0B0C0D, toggle: 1'b1, w0: 28'h1020304, w1: 28'hA0B0C0D, err: 1'b1};
    vecs[2] = '{cnt: 9'd1, bytes: 64'h0FFFFFFF_00000000, toggle: 1'b0, w0: 28'hFFFFFFF, w1: 28'h0, err: 1'b0};
    vecs[3] = '{cnt: 9'd2, bytes: 64'h71234567_89ABCDEF, toggle: 1'b1, w0: 28'h1234567, w1: 28'h9ABCDEF, err: 1'b1};

    repeat (3) @(negedge Clock);
    check("rstCpuReset", 64'(cpuRst), 64'(1));
    check("rstByteReady", 64'(rdy), 64'(0));
    check("rstWriteEnable", 64'(we), 64'(0));
    check("rstDone", 64'(done), 64'(0));
    check("rstBusy", 64'(busy), 64'(0));
    check("rstError", 64'(err), 64'(0));
    check("rstAddress", 64'(wa), 64'(0));
    check("rstData", 64'(wd), 64'(0));
    Reset = 1'b1;
    iByte = 8'h55;
    iByteValid = 1'b1;
    repeat (3) @(negedge Clock);
    check("idleIgnoresValidBusy", 64'(busy), 64'(0));
    check("idleIgnoresValidReady", 64'(rdy), 64'(0));
    iByteValid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      log8.delete();
      logS.delete();
      for (int i = 0; i < 8; i++) img[i] = vecs[v].bytes[63-8*i -: 8];
      startLoad(vecs[v].cnt);
      sendBytes(0, 4 * int'(vecs[v].cnt), vecs[v].toggle);
      sendSum(1'b0);
      waitDone();
      check($sformatf("v%0d writes", v), 64'(log8.size()), 64'(vecs[v].cnt));
      for (int k = 0; k < int'(vecs[v].cnt) && k < log8.size(); k++) begin
        check($sformatf("v%0d addr%0d", v, k), 64'(log8[k][35:28]), 64'(k));
        check($sformatf("v%0d data%0d", v, k), 64'(log8[k][27:0]), 64'(k == 0 ? vecs[v].w0 : vecs[v].w1));
      end
      check($sformatf("v%0d error", v), 64'(err), 64'(vecs[v].err));
      check($sformatf("v%0d cpuReset", v), 64'(cpuRst), 64'(0));
      check($sformatf("v%0d busy", v), 64'(busy), 64'(0));
    end

    // reload from DONE, then abort with reset partway through word 1
    for (int i = 0; i < 8; i++) img[i] = vecs[0].bytes[63-8*i -: 8];
    log8.delete();
    startLoad(9'd2);
    check("reloadCpuReset", 64'(cpuRst), 64'(1));
    check("reloadBusy", 64'(busy), 64'(1));
    check("reloadAddress", 64'(wa), 64'(0));
    sendBytes(0, 6, 1'b0);
    Reset = 1'b0;
    @(negedge Clock);
    check("abortWrites", 64'(log8.size()), 64'(1));
    check("abortCpuReset", 64'(cpuRst), 64'(1));
    check("abortBusy", 64'(busy), 64'(0));
    check("abortDone", 64'(done), 64'(0));
    check("abortAddress", 64'(wa), 64'(0));
    Reset = 1'b1;

    log8.delete();
    startLoad(9'd0);
`ifdef LOADER_CHECKSUM_EN
    check("zeroCountCheckBusy", 64'(busy), 64'(1));
    sendSum(1'b0);
`else
    check("zeroCountDone", 64'(done), 64'(1));
`endif
    waitDone();
    check("zeroCountWrites", 64'(log8.size()), 64'(0));
    check("zeroCountError", 64'(err), 64'(0));

    log8.delete();
    startLoad(9'd1);
    sendBytes(0, 2, 1'b0);
    iStart = 1'b1;
    iWordCount = 9'd3;
    @(negedge Clock);
    iStart = 1'b0;
    check("startWhileBusy", 64'(busy), 64'(1));
    sendBytes(2, 2, 1'b0);
    sendSum(1'b0);
    waitDone();
    check("startWhileBusyWrites", 64'(log8.size()), 64'(1));
    check("startWhileBusyAddress", 64'(wa), 64'(1));

    // 2-bit address instance wraps after four words
    for (int k = 0; k < 5; k++) begin
      img[4*k]   = 8'(k);
      img[4*k+1] = 8'(8'h10 + k);
      img[4*k+2] = 8'(8'h20 + k);
      img[4*k+3] = 8'(8'h30 + k);
    end
    log8.delete();
    logS.delete();
    startLoad(9'd5);
    sendBytes(0, 20, 1'b0);
    sendSum(1'b1);
    waitDone();
    check("wrapWrites", 64'(logS.size()), 64'(5));
    for (int k = 0; k < 5 && k < logS.size(); k++) begin
      check($sformatf("wrapAddr%0d", k), 64'(logS[k][29:28]), 64'(k % 4));
      check($sformatf("wrapData%0d", k), 64'(logS[k][27:0]),
            64'({4'(k), 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)}));
    end
    check("wideAddr4", 64'(log8.size() > 4 ? log8[4][35:28] : 8'hFF), 64'(4));
    check("wrapDone", 64'(doneS), 64'(1));
`ifdef LOADER_CHECKSUM_EN
    check("wrapBadChecksumError", 64'(errS), 64'(1));
`else
    check("wrapError", 64'(errS), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
